// File: rtl/logicnets_pkg.sv
// Constants and helpers shared by the LogicNets stream adapters and the
// layer-1 neuron generator.
package logicnets_pkg;

  localparam int DEF_NUM_FEATURES = 16;
  localparam int DEF_IN_BITS      = 2;

  // Bit offset of feature k inside a packed frame.
  function automatic int feat_offset(input int k, input int bits);
    return k * bits;
  endfunction

endpackage

// File: rtl/logicnets_input_packer.sv
// Packs a stream of quantized features, one per beat, into a registered wide
// frame that feeds the layer-1 neuron LUT inputs.
module logicnets_input_packer
  import logicnets_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int IN_BITS      = DEF_IN_BITS,
  parameter int CNT_W        = $clog2(NUM_FEATURES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_BITS-1:0]              s_data,
  input  logic                            s_valid,
  input  logic                            s_last,
  output logic                            s_ready,
  output logic [NUM_FEATURES*IN_BITS-1:0] m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            frame_err
);

  localparam int               FRAME_W  = NUM_FEATURES * IN_BITS;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_FEATURES - 1);

  logic [CNT_W-1:0]   idx;
  logic [FRAME_W-1:0] acc;
  logic [FRAME_W-1:0] acc_next;
  logic               at_last;
  logic               accept;
  logic               complete;
  logic               early_last;
  logic               missing_last;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid never waits on ready; s_ready depends combinationally on m_ready,
  // and only the completing beat can be stalled, when the held frame has
  // not yet been taken.
  assign at_last      = (idx == LAST_IDX);
  assign s_ready      = !(at_last && m_valid && !m_ready);
  assign accept       = s_valid && s_ready;
  assign complete     = accept && at_last;
  assign early_last   = accept && s_last && !at_last;
  assign missing_last = complete && !s_last;

  always_comb begin
    acc_next = acc;
    acc_next[feat_offset(int'(idx), IN_BITS) +: IN_BITS] = s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      acc       <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= early_last || missing_last;
      if (accept) begin
        if (complete || early_last) begin
          idx <= '0;
          acc <= '0;
        end else begin
          idx <= idx + CNT_W'(1);
          acc <= acc_next;
        end
      end
      // A completing frame replaces the one being taken this cycle, so a
      // back-to-back frame leaves m_valid high with no bubble.
      if (complete) begin
        m_data  <= acc_next;
        m_valid <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/logicnets_input_packer.md
Name: logicnets_input_packer

Overview:
- Upstream stage of the LogicNets layer-1 neuron array.
- Accepts a stream of quantized input features, one feature per beat, over a valid/ready interface.
- Packs one frame of NUM_FEATURES features into a single wide vector.
- Holds that vector in a registered output, with valid/ready, that drives the combinational layer-1 neuron LUT inputs. Downstream back-pressure never corrupts a frame.

Parameters:
- NUM_FEATURES, 16, features per frame (>=2).
- IN_BITS, 2, bits per quantized feature.
- CNT_W, $clog2(NUM_FEATURES), width of the feature index counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data  in  IN_BITS  quantized feature value.
- s_valid  in  1  s_data is valid this cycle.
- s_last  in  1  marks the final feature of a frame.
- s_ready  out  1  packer can accept a beat this cycle.
- m_data  out  NUM_FEATURES*IN_BITS  packed frame; feature k occupies bits [k*IN_BITS +: IN_BITS].
- m_valid  out  1  m_data holds a complete frame.
- m_ready  in  1  consumer accepts m_data this cycle.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, frame_err=0, idx=0, accumulator=0. s_ready=1 out of reset.
- Beat accepted when s_valid && s_ready. On acceptance:
  - acc[idx*IN_BITS +: IN_BITS] <= s_data.
  - idx increments.
- Registers:
  - Accumulator (acc) and output register (m_data) are separate.
  - Filling of the next frame continues while the previous frame is still held on m_data.
- Frame completion:
  - A beat accepted with idx==NUM_FEATURES-1 completes the frame.
  - Next cycle: m_data = acc with the final feature merged in, m_valid=1, idx=0.
  - Latency from last accepted beat to m_valid: 1 cycle.
- Output handshake:
  - m_valid && m_ready clears m_valid next cycle, unless a new frame completes in the same cycle. In that case m_valid stays 1 and m_data loads the new frame (back-to-back, no bubble).
  - m_data is stable while m_valid && !m_ready.
- s_ready = !(idx==NUM_FEATURES-1 && m_valid && !m_ready).
  - Only the completing beat stalls; earlier beats always accepted.
  - Combinational path from m_ready to s_ready is permitted and documented.
- Framing rules:
  - s_last accepted with idx<NUM_FEATURES-1 (early last): discard the partial frame; idx<=0; frame_err pulses; m_valid/m_data unaffected.
  - Beat accepted at idx==NUM_FEATURES-1 without s_last: frame still emitted normally; frame_err pulses; next beat starts a new frame.
  - s_last at idx==NUM_FEATURES-1: normal; no error.
- frame_err is registered, high exactly one cycle per offending beat.
- idx never exceeds NUM_FEATURES-1; wrap to 0 only via completion or early last.
- Reset mid-frame or mid-hold: partial frame and pending output dropped, all state as at reset; no frame_err generated by reset.
- No combinational path from s_data to m_data.

Decomposition:
- Shared package logicnets_pkg holds:
  - Default NUM_FEATURES and IN_BITS constants, shared with the layer-1 neuron generator.
  - A function returning the bit offset of feature k.
- No sub-module required. Optional one: logicnets_frame_counter (idx counter plus last/error detection) if reused by other stream adapters.

Test Plan (NUM_FEATURES=4, IN_BITS=2 unless noted):
- Normal frame: send 2'b01,2'b10,2'b11,2'b00 with s_last on 4th beat, m_ready=1 -> m_valid high 1 cycle after 4th beat, m_data=8'b00_11_10_01, frame_err=0.
- Back-pressure: hold m_ready=0, send two full frames back-to-back:
  - First frame held stable.
  - Second frame's 4th beat sees s_ready=0 until m_ready=1.
  - Then m_data switches to frame 2 with no bubble.
- Early last: s_last on 2nd beat -> frame_err pulses 1 cycle, no m_valid. The following 4-beat frame emits correctly.
- Missing last: 4 beats with s_last=0 -> frame emitted, frame_err pulse 1 cycle after 4th beat.
- Reset mid-frame: assert rst asynchronously after 2 beats and while m_valid=1 -> m_valid=0 and m_data=0 immediately. The next full frame emits correct data.
- Default params (16x2): random stream of 100 frames with random s_valid/m_ready gaps -> scoreboard matches every packed 32-bit vector in order, zero frame_err.
